// File: rtl/mem_stage_defs.sv
// mem_stage_defs: shared funct3 codes, FSM states and lane width for the memory stage
package mem_stage_defs;
    localparam int BE_W = 4;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
endpackage

// File: rtl/mem_align.sv
// mem_align: store lane replication/byte enables, alignment check and load extraction
module mem_align
    import mem_stage_defs::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr,
    input  logic [31:0]     rd2,
    input  logic [31:0]     rdata,
    output logic [BE_W-1:0] be,
    output logic [31:0]     wdata,
    output logic            misalign,
    output logic [31:0]     load
);
    logic [31:0] sh;
    logic        sx;
    always_comb begin
        sh       = rdata >> {addr, 3'b000};
        sx       = ~funct3[2];
        be       = funct3[1:0] == F3_B[1:0] ? 4'b0001 << addr :
                   funct3[1:0] == F3_H[1:0] ? 4'b0011 << addr : 4'b1111;
        wdata    = funct3[1:0] == F3_B[1:0] ? {4{rd2[7:0]}} :
                   funct3[1:0] == F3_H[1:0] ? {2{rd2[15:0]}} : rd2;
        misalign = (funct3[1:0] == F3_H[1:0] && addr[0]) ||
                   (funct3[1:0] == F3_W[1:0] && addr != 2'b00);
        load     = funct3[1:0] == F3_B[1:0] ? {{24{sh[7] & sx}}, sh[7:0]} :
                   funct3[1:0] == F3_H[1:0] ? {{16{sh[15] & sx}}, sh[15:0]} : rdata;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: req/ack data-memory access stage with registered writeback.
// MEM_STAGE_TIMEOUT_EN adds an ACCESS watchdog of TIMEOUT cycles.
module mem_stage
    import mem_stage_defs::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     ex_z,
    input  logic [31:0]     ex_rd2,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd,
    input  logic            reg_write,
    input  logic            mem_to_reg,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [31:0]     dmem_addr,
    output logic [31:0]     dmem_wdata,
    output logic [BE_W-1:0] dmem_be,
    input  logic            dmem_ack,
    input  logic [31:0]     dmem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic            wb_reg_write,
    output logic [31:0]     wb_data,
    output logic            err
);
    state_t          state_q;
    logic [31:0]     addr_q, wdata_q, wb_data_q;
    logic [BE_W-1:0] be_q;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q, wb_rd_q;
    logic            we_q, re_q, rw_q, m2r_q, wb_valid_q, wb_rw_q, err_q;
    logic [BE_W-1:0] st_be;
    logic [31:0]     st_wdata, ld_data;
    logic            misalign, mem_op, fault;
    // The aligner sees live inputs while idle and the latched access afterwards
    mem_align u_align (
        .funct3  (state_q == IDLE ? funct3 : f3_q),
        .addr    (state_q == IDLE ? ex_z[1:0] : addr_q[1:0]),
        .rd2     (ex_rd2),
        .rdata   (dmem_rdata),
        .be      (st_be),
        .wdata   (st_wdata),
        .misalign(misalign),
        .load    (ld_data)
    );
    assign mem_op = mem_read | mem_write;
    assign fault  = mem_op && ((mem_read && mem_write) || funct3 == 3'b011 ||
                    funct3[2:1] == 2'b11 || (mem_write && funct3[2]) || misalign);
`ifdef MEM_STAGE_TIMEOUT_EN
    logic [7:0] cnt_q;
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT[0];
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            rw_q       <= 1'b0;
            m2r_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_rw_q    <= 1'b0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    addr_q  <= ex_z;
                    wdata_q <= mem_read ? 32'h0 : st_wdata;
                    be_q    <= mem_read ? 4'hf : st_be;
                    we_q    <= mem_write;
                    re_q    <= mem_read;
                    rw_q    <= reg_write;
                    m2r_q   <= mem_to_reg;
                    f3_q    <= funct3;
                    rd_q    <= rd;
`ifdef MEM_STAGE_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                    if (!mem_op || fault) begin
                        state_q    <= RESP;
                        wb_valid_q <= 1'b1;
                        err_q      <= fault;
                        wb_rd_q    <= rd;
                        wb_rw_q    <= reg_write && !fault;
                        wb_data_q  <= ex_z;
                    end else begin
                        state_q <= ACCESS;
                    end
                end
                ACCESS: if (dmem_ack) begin
                    state_q    <= RESP;
                    wb_valid_q <= 1'b1;
                    wb_rd_q    <= rd_q;
                    wb_rw_q    <= re_q && rw_q;
                    wb_data_q  <= re_q && m2r_q ? ld_data : addr_q;
                end
`ifdef MEM_STAGE_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_q    <= RESP;
                    wb_valid_q <= 1'b1;
                    err_q      <= 1'b1;
                    wb_rd_q    <= rd_q;
                    wb_rw_q    <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
`endif
                RESP: begin
                    state_q    <= IDLE;
                    wb_valid_q <= 1'b0;
                    err_q      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign in_ready     = state_q == IDLE;
    assign dmem_req     = state_q == ACCESS;
    assign dmem_we      = we_q;
    assign dmem_addr    = {addr_q[31:2], 2'b00};
    assign dmem_wdata   = wdata_q;
    assign dmem_be      = be_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_rw_q;
    assign wb_data      = wb_data_q;
    assign err          = err_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table plus reset, stray-ack and timeout sequences
module tb_mem_stage;
`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 0, in_ready, mem_read = 0, mem_write = 0, reg_write = 0, mem_to_reg = 0;
    logic [31:0] ex_z = 0, ex_rd2 = 0, dmem_addr, dmem_wdata, dmem_rdata = 0, wb_data;
    logic [2:0] funct3 = 0;
    logic [4:0] rd = 0, wb_rd;
    logic dmem_req, dmem_we, dmem_ack = 0, wb_valid, wb_reg_write, err;
    logic [3:0] dmem_be;
    int total = 0, bad = 0;
    always #5 clk = ~clk;
    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ex_z(ex_z), .ex_rd2(ex_rd2), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .rd(rd), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .wb_data(wb_data), .err(err)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    task automatic issue(input logic [31:0] z, input logic [31:0] r2, input logic [4:0] d,
                         input logic mr, input logic mw, input logic rw, input logic m2r,
                         input logic [2:0] f3);
        ex_z = z; ex_rd2 = r2; rd = d; mem_read = mr; mem_write = mw;
        reg_write = rw; mem_to_reg = m2r; funct3 = f3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask
    typedef struct {
        logic [31:0] ex_z, rd2, rdata;
        logic [4:0]  rd;
        logic        mr, mw, rw, m2r;
        logic [2:0]  f3;
        int          d;
        logic        acc;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we, cwd;
        logic [31:0] wbd;
        logic        wrw, er;
    } vec_t;
    vec_t v [15];
    logic [4:0] prev_rd;
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
    initial begin
        v[0]  = '{32'h1234, 0, 0, 5'd1, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 32'h1234, 1, 0};
        v[1]  = '{32'h103, 32'hAB, 0, 5'd2, 0, 1, 0, 0, 3'b000, 3, 1, 32'h100, 4'b1000, 32'hABABABAB, 1, 0, 0, 0, 0};
        v[2]  = '{32'h200, 0, 32'h80FF7F01, 5'd3, 1, 0, 1, 1, 3'b000, 2, 1, 32'h200, 4'hf, 0, 0, 1, 32'h00000001, 1, 0};
        v[3]  = '{32'h203, 0, 32'h80FF7F01, 5'd4, 1, 0, 1, 1, 3'b000, 1, 1, 32'h200, 4'hf, 0, 0, 1, 32'hFFFFFF80, 1, 0};
        v[4]  = '{32'h202, 0, 32'h80FF7F01, 5'd5, 1, 0, 1, 1, 3'b101, 2, 1, 32'h200, 4'hf, 0, 0, 1, 32'h000080FF, 1, 0};
        v[5]  = '{32'h200, 0, 32'h80FF7F01, 5'd6, 1, 0, 1, 1, 3'b010, 1, 1, 32'h200, 4'hf, 0, 0, 1, 32'h80FF7F01, 1, 0};
        v[6]  = '{32'h102, 0, 0, 5'd7, 1, 0, 1, 1, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        v[7]  = '{32'h200, 0, 0, 5'd8, 1, 0, 1, 1, 3'b111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        v[8]  = '{32'h102, 32'h5566CAFE, 0, 5'd9, 0, 1, 1, 0, 3'b001, 2, 1, 32'h100, 4'b1100, 32'hCAFECAFE, 1, 0, 0, 0, 0};
        v[9]  = '{32'h300, 32'hDEADBEEF, 0, 5'd10, 0, 1, 0, 0, 3'b010, 1, 1, 32'h300, 4'hf, 32'hDEADBEEF, 1, 0, 0, 0, 0};
        v[10] = '{32'h200, 0, 32'h1234F00D, 5'd11, 1, 0, 1, 1, 3'b001, 2, 1, 32'h200, 4'hf, 0, 0, 1, 32'hFFFFF00D, 1, 0};
        v[11] = '{32'h200, 0, 0, 5'd12, 1, 1, 1, 1, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        v[12] = '{32'h200, 0, 0, 5'd13, 0, 1, 1, 0, 3'b100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        v[13] = '{32'h55, 0, 0, 5'd14, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 32'h55, 0, 0};
        v[14] = '{32'h202, 0, 32'h80FF7F01, 5'd15, 1, 0, 1, 1, 3'b100, 1, 1, 32'h200, 4'hf, 0, 0, 1, 32'h000000FF, 1, 0};
        #12 rst_n = 1'b1;
        @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 1);
        chk("rst dmem_req", 32'(dmem_req), 0);
        chk("rst wb_valid", 32'(wb_valid), 0);
        chk("rst err", 32'(err), 0);
        chk("rst dmem_addr", dmem_addr, 0);
        chk("rst wb_data", wb_data, 0);
        @(posedge clk); #1;
        prev_rd = 0;
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("v%0d in_ready idle", i), 32'(in_ready), 1);
            issue(v[i].ex_z, v[i].rd2, v[i].rd, v[i].mr, v[i].mw, v[i].rw, v[i].m2r, v[i].f3);
            chk($sformatf("v%0d in_ready busy", i), 32'(in_ready), 0);
            chk($sformatf("v%0d dmem_req", i), 32'(dmem_req), 32'(v[i].acc));
            if (v[i].acc) begin
                chk($sformatf("v%0d wb_rd hold", i), 32'(wb_rd), 32'(prev_rd));
                for (int c = 1; c <= v[i].d; c++) begin
                    chk($sformatf("v%0d req c%0d", i, c), 32'(dmem_req), 1);
                    chk($sformatf("v%0d addr c%0d", i, c), dmem_addr, v[i].addr);
                    chk($sformatf("v%0d be c%0d", i, c), 32'(dmem_be), 32'(v[i].be));
                    chk($sformatf("v%0d wdata c%0d", i, c), dmem_wdata, v[i].wdata);
                    chk($sformatf("v%0d we c%0d", i, c), 32'(dmem_we), 32'(v[i].we));
                    chk($sformatf("v%0d wbv c%0d", i, c), 32'(wb_valid), 0);
                    chk($sformatf("v%0d rdy c%0d", i, c), 32'(in_ready), 0);
                    dmem_ack = (c == v[i].d);
                    dmem_rdata = (c == v[i].d) ? v[i].rdata : 32'hDEAD0000;
                    @(posedge clk); #1;
                end
                dmem_ack = 1'b0;
                chk($sformatf("v%0d req drop", i), 32'(dmem_req), 0);
            end
            chk($sformatf("v%0d wb_valid", i), 32'(wb_valid), 1);
            chk($sformatf("v%0d err", i), 32'(err), 32'(v[i].er));
            chk($sformatf("v%0d wb_rd", i), 32'(wb_rd), 32'(v[i].rd));
            chk($sformatf("v%0d wb_reg_write", i), 32'(wb_reg_write), 32'(v[i].wrw));
            if (v[i].cwd) chk($sformatf("v%0d wb_data", i), wb_data, v[i].wbd);
            @(posedge clk); #1;
            chk($sformatf("v%0d wb_valid pulse", i), 32'(wb_valid), 0);
            chk($sformatf("v%0d err pulse", i), 32'(err), 0);
            chk($sformatf("v%0d wb_rd held", i), 32'(wb_rd), 32'(v[i].rd));
            prev_rd = v[i].rd;
        end
        dmem_ack = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("stray ack wb_valid", 32'(wb_valid), 0);
        chk("stray ack in_ready", 32'(in_ready), 1);
        chk("stray ack req", 32'(dmem_req), 0);
        issue(32'h200, 0, 5'd20, 1, 0, 1, 1, 3'b010);
        chk("pre-reset req", 32'(dmem_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset req", 32'(dmem_req), 0);
        chk("async reset in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        chk("reset no wb", 32'(wb_valid), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("after reset in_ready", 32'(in_ready), 1);
`ifdef MEM_STAGE_TIMEOUT_EN
        begin
            int n = 0;
            issue(32'h400, 0, 5'd21, 1, 0, 1, 1, 3'b010);
            while (dmem_req && n < 40) begin
                n++;
                @(posedge clk); #1;
            end
            chk("timeout access cycles", 32'(n), 4);
            chk("timeout wb_valid", 32'(wb_valid), 1);
            chk("timeout err", 32'(err), 1);
            chk("timeout wb_reg_write", 32'(wb_reg_write), 0);
            @(posedge clk); #1;
            chk("timeout idle", 32'(in_ready), 1);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
